// File: rtl/segseq_ctl.sv
// rtl/segseq_ctl.sv - expands a block command into per-word segment ops and buffers read returns
module segseq_ctl #(
  parameter int AW = 4,
  parameter int DW = 8,
  parameter int LW = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_base,
  input  logic [LW-1:0] cmd_len,
  input  logic          cmd_write,
  input  logic [DW-1:0] wdata,
  input  logic          wdata_valid,
  output logic          wdata_ready,
  output logic [AW-1:0] seg_addr,
  output logic [DW-1:0] seg_dataW,
  output logic          seg_write,
  output logic          seg_valid,
  input  logic          seg_ready,
  input  logic [DW-1:0] seg_dataR,
  input  logic          seg_dataR_valid,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  input  logic          rdata_ready,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  // Command context: current address, ops still to issue, block direction.
  logic [AW-1:0] addr_q;
  logic [LW-1:0] remain_q;
  logic          mode_wr_q;

  // Reads issued to the segment whose data has not yet come back.
  logic [1:0]    outst_q;
  logic [1:0]    outst_nxt;

  // Two-entry read return FIFO.
  logic [DW-1:0] buf_mem [2];
  logic          buf_wp;
  logic          buf_rp;
  logic [1:0]    buf_cnt;
  logic [1:0]    buf_cnt_nxt;

  logic          done_q;
  logic          done_set;

  logic          cmd_fire;
  logic          op_fire;
  logic          last_fire;
  logic          rd_fire;
  logic          ret_ok;
  logic          push;
  logic          pop;
  logic [2:0]    inflight;
  logic          rd_room;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign op_fire   = seg_valid & seg_ready;
  assign last_fire = op_fire & (remain_q == LW'(1));
  assign rd_fire   = op_fire & ~mode_wr_q;

  // A return with nothing outstanding is a protocol error; drop it entirely.
  assign ret_ok    = seg_dataR_valid & (outst_q != 2'd0);
  assign push      = ret_ok;
  assign pop       = rdata_valid & rdata_ready;

  // Issuing only while in-flight plus buffered words is below two guarantees
  // every returning word has a buffer slot, so push never meets a full FIFO.
  assign inflight  = {1'b0, outst_q} + {1'b0, buf_cnt};
  assign rd_room   = (inflight < 3'd2);

  assign buf_cnt_nxt = buf_cnt + {1'b0, push} - {1'b0, pop};

  // Outstanding count: read issue adds one, accepted return removes one.
  always_comb begin
    outst_nxt = outst_q;
    if (rd_fire && !ret_ok) begin
      outst_nxt = outst_q + 2'd1;
    end else if (!rd_fire && ret_ok) begin
      outst_nxt = outst_q - 2'd1;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; also decides when the completion pulse is due.
  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_len == '0) begin
            done_set = 1'b1;
          end else begin
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (last_fire) begin
          if (mode_wr_q) begin
            state_nxt = IDLE;
            done_set  = 1'b1;
          end else begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Look at next-cycle occupancy so done follows the final pop by one cycle.
        if (outst_nxt == 2'd0 && buf_cnt_nxt == 2'd0) begin
          state_nxt = IDLE;
          done_set  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode: write data passes straight through, reads are throttled by buffer room.
  always_comb begin
    cmd_ready   = (state == IDLE);
    seg_addr    = addr_q;
    seg_write   = 1'b0;
    seg_dataW   = '0;
    seg_valid   = 1'b0;
    wdata_ready = 1'b0;
    if (state == ISSUE) begin
      if (mode_wr_q) begin
        seg_write   = 1'b1;
        seg_dataW   = wdata;
        seg_valid   = wdata_valid;
        wdata_ready = seg_ready;
      end else begin
        seg_valid   = rd_room;
      end
    end
    rdata       = buf_mem[buf_rp];
    rdata_valid = (buf_cnt != 2'd0);
    done        = done_q;
  end

  // Command context registers and the registered completion pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q    <= '0;
      remain_q  <= '0;
      mode_wr_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= done_set;
      if (cmd_fire && (cmd_len != '0)) begin
        addr_q    <= cmd_base;
        remain_q  <= cmd_len;
        mode_wr_q <= cmd_write;
      end else if (op_fire) begin
        addr_q   <= addr_q + AW'(1);
        remain_q <= remain_q - LW'(1);
      end
    end
  end

  // Outstanding counter and FIFO pointers; reset discards any buffered words.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outst_q <= 2'd0;
      buf_wp  <= 1'b0;
      buf_rp  <= 1'b0;
      buf_cnt <= 2'd0;
    end else begin
      outst_q <= outst_nxt;
      buf_cnt <= buf_cnt_nxt;
      if (push) begin
        buf_wp <= ~buf_wp;
      end
      if (pop) begin
        buf_rp <= ~buf_rp;
      end
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clock) begin
    if (push) begin
      buf_mem[buf_wp] <= seg_dataR;
    end
  end

endmodule

// File: tb/tb_segseq_ctl.sv
// tb/tb_segseq_ctl.sv - self-checking bench for segseq_ctl with a block-level reference model
`timescale 1ns/1ps
module tb_segseq_ctl;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int LW = 5;

  logic          clock;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base;
  logic [LW-1:0] cmd_len;
  logic          cmd_write;
  logic [DW-1:0] wdata;
  logic          wdata_valid;
  logic          wdata_ready;
  logic [AW-1:0] seg_addr;
  logic [DW-1:0] seg_dataW;
  logic          seg_write;
  logic          seg_valid;
  logic          seg_ready;
  logic [DW-1:0] seg_dataR;
  logic          seg_dataR_valid;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          rdata_ready;
  logic          done;

  segseq_ctl #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base),
    .cmd_len(cmd_len), .cmd_write(cmd_write),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .seg_addr(seg_addr), .seg_dataW(seg_dataW), .seg_write(seg_write),
    .seg_valid(seg_valid), .seg_ready(seg_ready),
    .seg_dataR(seg_dataR), .seg_dataR_valid(seg_dataR_valid),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
    .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  // Segment contents and write-stream words.
  logic [DW-1:0] mem    [16];
  logic [DW-1:0] wwords [16];

  // Segment responder: one return per read op, in order, after seg_lat cycles.
  typedef struct { int due; logic [DW-1:0] d; } ret_t;
  ret_t ret_q[$];
  int   seg_lat = 1;
  bit   spur = 1'b0;

  initial begin
    seg_dataR       = '0;
    seg_dataR_valid = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) ret_q.delete();
      else if (seg_valid && seg_ready && !seg_write) ret_q.push_back('{cyc + seg_lat, mem[seg_addr]});
      @(posedge clock);
      #2;
      seg_dataR_valid = 1'b0;
      seg_dataR       = '0;
      if (!reset) begin
        ret_q.delete();
      end else if (spur) begin
        seg_dataR_valid = 1'b1;
        seg_dataR       = 8'hEE;
      end else if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        seg_dataR_valid = 1'b1;
        seg_dataR       = ret_q[0].d;
        ret_q.pop_front();
      end
    end
  end

  // Reference model: a command is a list of expected ops; reads produce an ordered list of words.
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic wr; int c; } op_t;
  op_t           exp_ops[$];
  logic [DW-1:0] rd_exp[$];
  int            m_out, m_buf, done_due, max_occ;
  bit            cur_wr;

  op_t           fire_log[$];
  logic [DW-1:0] rd_log[$];
  int            accept_cyc = -1, last_done_cyc = -1, last_pop_cyc = -1, done_count = 0;
  bit            rdy_at_done;
  bit            s_whs, s_cmdhs, s_rhs;

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    exp_ops.delete();
    rd_exp.delete();
    m_out    = 0;
    m_buf    = 0;
    done_due = -10;
  endtask

  // Per-cycle comparison of DUT outputs against the model, then model update from handshakes.
  task automatic compare_cycle();
    op_t op;
    bit  idle_exp;
    if (!reset) begin
      chk("rst_seg_valid", int'(seg_valid), 0);
      chk("rst_wdata_ready", int'(wdata_ready), 0);
      chk("rst_rdata_valid", int'(rdata_valid), 0);
      chk("rst_done", int'(done), 0);
      model_clear();
      return;
    end
    idle_exp = (exp_ops.size() == 0) && (m_out == 0) && (m_buf == 0);
    chk("done", int'(done), int'(cyc == done_due));
    chk("cmd_ready", int'(cmd_ready), int'(idle_exp));
    chk("rdata_valid", int'(rdata_valid), int'(m_buf > 0));
    if (exp_ops.size() > 0) begin
      if (cur_wr) begin
        chk("seg_valid_wr", int'(seg_valid), int'(wdata_valid));
        chk("wdata_ready", int'(wdata_ready), int'(seg_ready));
      end else begin
        chk("seg_valid_rd", int'(seg_valid), int'((m_out + m_buf) < 2));
        chk("wdata_ready_rd", int'(wdata_ready), 0);
      end
    end else begin
      chk("seg_valid_idle", int'(seg_valid), 0);
      chk("wdata_ready_idle", int'(wdata_ready), 0);
    end
    if (done) begin
      last_done_cyc = cyc;
      done_count++;
      rdy_at_done = cmd_ready;
    end

    if (seg_valid && seg_ready && exp_ops.size() > 0) begin
      op = exp_ops.pop_front();
      chk("seg_addr", int'(seg_addr), int'(op.addr));
      chk("seg_dataW", int'(seg_dataW), int'(op.data));
      chk("seg_write", int'(seg_write), int'(op.wr));
      op.c = cyc;
      fire_log.push_back(op);
      if (op.wr) begin
        if (exp_ops.size() == 0) done_due = cyc + 1;
      end else begin
        m_out++;
        rd_exp.push_back(mem[op.addr]);
      end
    end
    if (seg_dataR_valid && m_out > 0) begin
      m_out--;
      m_buf++;
    end
    if (rdata_valid && rdata_ready && m_buf > 0) begin
      chk("rdata", int'(rdata), int'(rd_exp[0]));
      rd_log.push_back(rdata);
      rd_exp.pop_front();
      m_buf--;
      last_pop_cyc = cyc;
      if (!cur_wr && exp_ops.size() == 0 && m_out == 0 && m_buf == 0) done_due = cyc + 1;
    end
    if (m_out + m_buf > max_occ) max_occ = m_out + m_buf;

    if (cmd_valid && cmd_ready) begin
      accept_cyc = cyc;
      if (cmd_len == '0) begin
        done_due = cyc + 1;
      end else begin
        cur_wr = cmd_write;
        for (int i = 0; i < int'(cmd_len); i++) begin
          op.addr = AW'(int'(cmd_base) + i);
          op.data = cmd_write ? wwords[i] : '0;
          op.wr   = cmd_write;
          op.c    = 0;
          exp_ops.push_back(op);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clock);
    compare_cycle();
    s_whs   = wdata_valid && wdata_ready;
    s_cmdhs = cmd_valid && cmd_ready;
    s_rhs   = rdata_valid && rdata_ready;
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic [AW-1:0] base, input logic [LW-1:0] len, input logic wr);
    cmd_valid = 1'b1;
    cmd_base  = base;
    cmd_len   = len;
    cmd_write = wr;
    s_cmdhs   = 1'b0;
    for (int k = 0; k < 20 && !s_cmdhs; k++) step();
    if (!s_cmdhs) chk("cmd_accept_timeout", 0, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic run_write(input logic [AW-1:0] base, input logic [LW-1:0] len, input bit stall);
    int idx = 0;
    int d0  = done_count;
    bit fin = 1'b0;
    wdata       = wwords[0];
    wdata_valid = 1'b1;
    seg_ready   = 1'b1;
    send_cmd(base, len, 1'b1);
    for (int t = 0; t < 200 && !fin; t++) begin
      if (stall) begin
        wdata_valid = (idx < int'(len)) && (t % 2 == 0);
        seg_ready   = (t % 3 != 2);
      end else begin
        wdata_valid = (idx < int'(len));
      end
      wdata = (idx < 16) ? wwords[idx] : '0;
      step();
      if (s_whs) idx++;
      if (done_count > d0) fin = 1'b1;
    end
    if (!fin) chk("write_done_timeout", 0, 1);
    wdata_valid = 1'b0;
    seg_ready   = 1'b1;
  endtask

  task automatic run_read(input logic [AW-1:0] base, input logic [LW-1:0] len, input bit bp);
    int pops = 0;
    int held = 0;
    int d0   = done_count;
    bit fin  = 1'b0;
    rdata_ready = 1'b1;
    send_cmd(base, len, 1'b0);
    for (int t = 0; t < 300 && !fin; t++) begin
      if (bp && pops >= 2 && held < 5) begin
        rdata_ready = 1'b0;
        held++;
      end else begin
        rdata_ready = 1'b1;
      end
      step();
      if (s_rhs) pops++;
      if (done_count > d0) fin = 1'b1;
    end
    if (!fin) chk("read_done_timeout", 0, 1);
    rdata_ready = 1'b1;
  endtask

  int s;
  int r;
  int d0;
  logic [DW-1:0] exp_b;

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; cmd_write = 1'b0;
    wdata = '0; wdata_valid = 1'b0; seg_ready = 1'b1; rdata_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mem[i]    = 8'hA0 | 8'(i);
      wwords[i] = '0;
    end
    model_clear();
    max_occ = 0;
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("post_reset_cmd_ready", int'(cmd_ready), 1);
    chk("post_reset_rdata_valid", int'(rdata_valid), 0);

    // Back-to-back write block.
    for (int i = 0; i < 4; i++) wwords[i] = 8'(8'h11 * (i + 1));
    s = fire_log.size();
    run_write(4'd3, 5'd4, 1'b0);
    chk("wr_op_count", fire_log.size() - s, 4);
    if (fire_log.size() >= s + 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("wr_addr_lit", int'(fire_log[s+i].addr), 3 + i);
        chk("wr_data_lit", int'(fire_log[s+i].data), 'h11 * (i + 1));
        chk("wr_cycle_lit", fire_log[s+i].c, accept_cyc + 1 + i);
      end
      chk("wr_done_cycle", last_done_cyc, fire_log[s+3].c + 1);
    end
    chk("wr_ready_at_done", int'(rdy_at_done), 1);

    // Read block that wraps the address space.
    seg_lat = 1;
    s = fire_log.size();
    r = rd_log.size();
    run_read(4'd14, 5'd4, 1'b0);
    chk("rdwrap_pops", rd_log.size() - r, 4);
    if (rd_log.size() >= r + 4 && fire_log.size() >= s + 4) begin
      chk("rdwrap_w0", int'(rd_log[r+0]), 'hAE);
      chk("rdwrap_w1", int'(rd_log[r+1]), 'hAF);
      chk("rdwrap_w2", int'(rd_log[r+2]), 'hA0);
      chk("rdwrap_w3", int'(rd_log[r+3]), 'hA1);
      chk("rdwrap_a2", int'(fire_log[s+2].addr), 0);
    end
    chk("rdwrap_done_after_pop", last_done_cyc, last_pop_cyc + 1);

    // Read with consumer backpressure and latency-2 segment.
    seg_lat = 2;
    max_occ = 0;
    r = rd_log.size();
    run_read(4'd2, 5'd6, 1'b1);
    chk("bp_pops", rd_log.size() - r, 6);
    if (rd_log.size() >= r + 6) begin
      for (int i = 0; i < 6; i++) begin
        exp_b = 8'hA2 + 8'(i);
        chk("bp_word_lit", int'(rd_log[r+i]), int'(exp_b));
      end
    end
    chk("bp_max_occupancy", max_occ, 2);
    seg_lat = 1;

    // Write with sparse wdata and segment stalls, wrapping at the top.
    for (int i = 0; i < 5; i++) wwords[i] = 8'hC1 + 8'(i);
    s = fire_log.size();
    run_write(4'd13, 5'd5, 1'b1);
    chk("wst_op_count", fire_log.size() - s, 5);
    if (fire_log.size() >= s + 5) begin
      chk("wst_a0", int'(fire_log[s+0].addr), 13);
      chk("wst_a3", int'(fire_log[s+3].addr), 0);
      chk("wst_a4", int'(fire_log[s+4].addr), 1);
      chk("wst_d4", int'(fire_log[s+4].data), 'hC5);
    end

    // Zero-length command.
    s  = fire_log.size();
    d0 = done_count;
    send_cmd(4'd7, 5'd0, 1'b0);
    step();
    step();
    chk("zero_done_cycle", last_done_cyc, accept_cyc + 1);
    chk("zero_done_count", done_count - d0, 1);
    chk("zero_no_ops", fire_log.size() - s, 0);

    // Return with nothing outstanding must be ignored.
    spur = 1'b1;
    step();
    spur = 1'b0;
    step();
    chk("spur_rdata_valid", int'(rdata_valid), 0);

    // Reset in the middle of a read block.
    rdata_ready = 1'b0;
    s = fire_log.size();
    send_cmd(4'd5, 5'd5, 1'b0);
    for (int t = 0; t < 50 && (fire_log.size() - s) < 2; t++) step();
    chk("midrd_two_issued", fire_log.size() - s, 2);
    reset = 1'b0;
    #1;
    chk("midrd_seg_valid", int'(seg_valid), 0);
    chk("midrd_rdata_valid", int'(rdata_valid), 0);
    chk("midrd_done", int'(done), 0);
    chk("midrd_cmd_ready", int'(cmd_ready), 1);
    step();
    step();
    reset = 1'b1;
    rdata_ready = 1'b1;
    step();
    chk("midrd_rel_cmd_ready", int'(cmd_ready), 1);
    chk("midrd_rel_rdata_valid", int'(rdata_valid), 0);
    r = rd_log.size();
    run_read(4'd9, 5'd3, 1'b0);
    chk("fresh_pops", rd_log.size() - r, 3);
    if (rd_log.size() >= r + 3) begin
      chk("fresh_w0", int'(rd_log[r+0]), 'hA9);
      chk("fresh_w2", int'(rd_log[r+2]), 'hAB);
    end

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
